// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and the accelerator master.
// CPU has fixed priority; the accelerator gets a starvation escape and locked bursts.
module dmem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_BURST    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              acc_req,
    input  logic              acc_we,
    input  logic              acc_lock,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic              acc_gnt,
    output logic [DATA_W-1:0] acc_rdata,
    output logic              acc_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic {ARB, BURST} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_ACC} tag_t;

    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
    localparam logic [4:0] BURST_MAX  = 5'(MAX_BURST);

    state_t     state;
    tag_t       rdTag;
    logic [7:0] starveCnt;
    logic [4:0] beatCnt;
    logic       cpuReq, cpuGrant, accGrant, burstGo;

    always_comb begin
        cpuReq   = cpu_rd | cpu_wr;
        burstGo  = (state == BURST) & acc_req & acc_lock & (beatCnt < BURST_MAX);
        accGrant = 1'b0;
        cpuGrant = 1'b0;
        // A burst that ends without a locked request falls straight back to normal arbitration.
        if (!rst) begin
            if (burstGo)
                accGrant = 1'b1;
            else if (acc_req && (!cpuReq || starveCnt == STARVE_MAX))
                accGrant = 1'b1;
            else
                cpuGrant = cpuReq;
        end
    end

    always_comb begin
        mem_en    = accGrant | cpuGrant;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (accGrant) begin
            mem_we    = acc_we;
            mem_addr  = acc_addr;
            mem_wdata = acc_wdata;
        end else if (cpuGrant) begin
            mem_we    = cpu_wr;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    assign cpu_stall  = cpuReq & ~cpuGrant & ~rst;
    assign acc_gnt    = accGrant;
    assign cpu_rvalid = (rdTag == TAG_CPU);
    assign acc_rvalid = (rdTag == TAG_ACC);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign acc_rdata  = acc_rvalid ? mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ARB;
            rdTag     <= TAG_NONE;
            starveCnt <= '0;
            beatCnt   <= '0;
        end else begin
            if (!acc_req || accGrant)
                starveCnt <= '0;
            else if (starveCnt < STARVE_MAX)
                starveCnt <= starveCnt + 8'd1;

            if (burstGo) begin
                // The beat reaching MAX_BURST is the last locked one.
                if (beatCnt + 5'd1 == BURST_MAX) begin
                    state   <= ARB;
                    beatCnt <= '0;
                end else begin
                    beatCnt <= beatCnt + 5'd1;
                end
            end else if (accGrant && acc_lock && MAX_BURST > 1) begin
                state   <= BURST;
                beatCnt <= 5'd1;
            end else begin
                state   <= ARB;
                beatCnt <= '0;
            end

            if (cpuGrant && !cpu_wr)
                rdTag <= TAG_CPU;
            else if (accGrant && !acc_we)
                rdTag <= TAG_ACC;
            else
                rdTag <= TAG_NONE;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: CPU priority, starvation escape, locked bursts,
// read-return routing, rd+wr collision and reset during a burst.
module tb_dmem_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpu_rd, cpu_wr, cpu_stall, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr, acc_addr, mem_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata, acc_wdata, acc_rdata, mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              acc_req, acc_we, acc_lock, acc_gnt, acc_rvalid;
    logic              mem_en, mem_we;

    int nAssert = 0;
    int nFail   = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(8), .MAX_BURST(4)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .acc_req(acc_req), .acc_we(acc_we), .acc_lock(acc_lock), .acc_addr(acc_addr),
        .acc_wdata(acc_wdata), .acc_gnt(acc_gnt), .acc_rdata(acc_rdata), .acc_rvalid(acc_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] romVal(input logic [31:0] a);
        case (a)
            32'h100:   romVal = 32'hDEADBEEF;
            32'h10:    romVal = 32'h11;
            32'h20:    romVal = 32'h22;
            32'h4B000: romVal = 32'hA5A50000;
            default:   romVal = a ^ 32'h5A5A5A5A;
        endcase
    endfunction

    // Synchronous single-port read with one cycle of latency.
    always @(posedge clk)
        if (mem_en && !mem_we) mem_rdata <= romVal(mem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAssert++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic expA, expS;
        int   beat;
        cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
        acc_req = 0; acc_we = 0; acc_lock = 0; acc_addr = '0; acc_wdata = '0;

        // Reset state
        @(negedge clk);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
        chk("rst_acc_rvalid", 32'(acc_rvalid), 0);
        chk("rst_cpu_stall", 32'(cpu_stall), 0);
        chk("rst_acc_gnt", 32'(acc_gnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_acc_rdata", acc_rdata, 0);
        tick();
        rst = 0;
        tick();

        // CPU load alone
        cpu_rd = 1; cpu_addr = 32'h100;
        @(negedge clk);
        chk("ld_mem_en", 32'(mem_en), 1);
        chk("ld_mem_we", 32'(mem_we), 0);
        chk("ld_mem_addr", mem_addr, 32'h100);
        chk("ld_stall", 32'(cpu_stall), 0);
        tick();
        cpu_rd = 0;
        @(negedge clk);
        chk("ld_rvalid", 32'(cpu_rvalid), 1);
        chk("ld_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("ld_acc_rvalid", 32'(acc_rvalid), 0);
        chk("ld_idle_mem_en", 32'(mem_en), 0);
        tick();

        // Starvation escape: CPU stores every cycle, accelerator read waits 8 cycles
        cpu_wr = 1; cpu_addr = 32'h200; cpu_wdata = 32'h1;
        acc_req = 1; acc_we = 0; acc_lock = 0; acc_addr = 32'h4B000;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("starve_deny_gnt", 32'(acc_gnt), 0);
            chk("starve_deny_stall", 32'(cpu_stall), 0);
            tick();
        end
        @(negedge clk);
        chk("starve_force_gnt", 32'(acc_gnt), 1);
        chk("starve_force_stall", 32'(cpu_stall), 1);
        chk("starve_force_addr", mem_addr, 32'h4B000);
        tick();
        acc_req = 0;
        @(negedge clk);
        chk("starve_cpu_back", 32'(cpu_stall), 0);
        chk("starve_cpu_addr", mem_addr, 32'h200);
        chk("starve_acc_rvalid", 32'(acc_rvalid), 1);
        chk("starve_acc_rdata", acc_rdata, 32'hA5A50000);
        chk("starve_cnt_clear", 32'(u_dut.starveCnt), 0);
        tick();
        cpu_wr = 0;
        tick();

        // Locked burst of 6 writes, MAX_BURST=4, CPU storing until granted once after the burst
        cpu_wr = 1; cpu_addr = 32'h300; cpu_wdata = 32'h77;
        acc_req = 1; acc_we = 1; acc_lock = 1; beat = 0;
        acc_addr = 32'h4B000; acc_wdata = 32'hB0;
        for (int c = 1; c <= 16; c++) begin
            expA = (c >= 9 && c <= 12) || c == 14 || c == 15;
            expS = (c >= 9 && c <= 12);
            @(negedge clk);
            chk($sformatf("burst_gnt_c%0d", c), 32'(acc_gnt), 32'(expA));
            chk($sformatf("burst_stall_c%0d", c), 32'(cpu_stall), 32'(expS));
            if (expA) begin
                chk($sformatf("burst_addr_b%0d", beat), mem_addr, 32'h4B000 + 32'(4 * beat));
                chk($sformatf("burst_wdata_b%0d", beat), mem_wdata, 32'hB0 + 32'(beat));
                chk($sformatf("burst_we_b%0d", beat), 32'(mem_we), 1);
            end
            tick();
            if (expA) beat++;
            acc_addr  = 32'h4B000 + 32'(4 * beat);
            acc_wdata = 32'hB0 + 32'(beat);
            if (beat == 6) begin acc_req = 0; acc_lock = 0; end
            if (c == 13) cpu_wr = 0;
        end

        // Alternating reads CPU then accelerator
        cpu_rd = 1; cpu_addr = 32'h10;
        @(negedge clk);
        chk("alt_cpu_stall", 32'(cpu_stall), 0);
        chk("alt_cpu_addr", mem_addr, 32'h10);
        tick();
        cpu_rd = 0; acc_req = 1; acc_we = 0; acc_lock = 0; acc_addr = 32'h20;
        @(negedge clk);
        chk("alt_cpu_rvalid", 32'(cpu_rvalid), 1);
        chk("alt_cpu_rdata", cpu_rdata, 32'h11);
        chk("alt_acc_rvalid0", 32'(acc_rvalid), 0);
        chk("alt_acc_gnt", 32'(acc_gnt), 1);
        tick();
        acc_req = 0;
        @(negedge clk);
        chk("alt_acc_rvalid", 32'(acc_rvalid), 1);
        chk("alt_acc_rdata", acc_rdata, 32'h22);
        chk("alt_cpu_rvalid0", 32'(cpu_rvalid), 0);
        tick();

        // Load and store asserted together: treated as a store
        cpu_rd = 1; cpu_wr = 1; cpu_addr = 32'h40; cpu_wdata = 32'h55;
        $display("note: driving cpu_rd and cpu_wr together (illegal request, expect store)");
        @(negedge clk);
        chk("rw_mem_we", 32'(mem_we), 1);
        chk("rw_mem_wdata", mem_wdata, 32'h55);
        chk("rw_mem_addr", mem_addr, 32'h40);
        tick();
        cpu_rd = 0; cpu_wr = 0;
        @(negedge clk);
        chk("rw_no_rvalid", 32'(cpu_rvalid), 0);
        tick();

        // Reset during a burst with an accelerator read in flight
        acc_req = 1; acc_we = 0; acc_lock = 1; acc_addr = 32'h4B000;
        @(negedge clk);
        chk("rb_gnt", 32'(acc_gnt), 1);
        tick();
        rst = 1;
        @(negedge clk);
        chk("rb_acc_rvalid", 32'(acc_rvalid), 0);
        chk("rb_acc_rdata", acc_rdata, 0);
        chk("rb_acc_gnt", 32'(acc_gnt), 0);
        chk("rb_starve", 32'(u_dut.starveCnt), 0);
        tick();
        rst = 0; acc_req = 0; acc_lock = 0;
        cpu_rd = 1; cpu_addr = 32'h100;
        @(negedge clk);
        chk("rb_cpu_stall", 32'(cpu_stall), 0);
        chk("rb_cpu_mem_en", 32'(mem_en), 1);
        chk("rb_acc_rvalid2", 32'(acc_rvalid), 0);
        tick();
        cpu_rd = 0;
        @(negedge clk);
        chk("rb_cpu_rvalid", 32'(cpu_rvalid), 1);
        chk("rb_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port synchronous data memory between the processor MEM stage and the image accelerator's memory master. Decides the grant every cycle: CPU has fixed priority, the accelerator has a starvation guarantee and locked bursts. Drives the pipeline stall, and routes 1-cycle-latency read data back to the requester that issued the read. Sits between the memory stage and the dmem macro.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 8, consecutive denied accelerator cycles before a forced accelerator grant (1..255)
MAX_BURST, 4, maximum beats in one locked accelerator burst (1..16)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cpu_rd  in  1  MEM-stage load request
cpu_wr  in  1  MEM-stage store request
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU store data
cpu_stall  out  1  CPU request not granted this cycle; hold the pipeline
cpu_rdata  out  DATA_W  load data
cpu_rvalid  out  1  cpu_rdata valid
acc_req  in  1  accelerator request
acc_we  in  1  accelerator write (1) / read (0)
acc_lock  in  1  request continues as a locked burst
acc_addr  in  ADDR_W  accelerator address
acc_wdata  in  DATA_W  accelerator write data
acc_gnt  out  1  accelerator request accepted this cycle
acc_rdata  out  DATA_W  accelerator read data
acc_rvalid  out  1  acc_rdata valid
mem_en  out  1  memory access enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after a read access

Behaviour:
- Reset values: state=ARB, starve_cnt=0, beat_cnt=0, rd_tag=NONE. cpu_rvalid, acc_rvalid, cpu_stall, acc_gnt and mem_en are 0. Read-data outputs are 0.
- cpu_req = cpu_rd | cpu_wr. If both are asserted, the access is a write and the read is ignored; the bench flags this as an error.
- Grant logic and the mem_* mux are combinational from the current state and the requests. Only one requester is granted per cycle.
- State ARB:
  - Accelerator wins if acc_req and (!cpu_req or starve_cnt==STARVE_LIMIT). Otherwise CPU wins if cpu_req.
  - On an accelerator grant with acc_lock=1 and MAX_BURST>1: go to BURST, beat_cnt=1.
- State BURST:
  - Accelerator keeps priority while acc_req & acc_lock and beat_cnt<MAX_BURST. beat_cnt increments per granted beat.
  - Return to ARB when acc_lock drops, acc_req drops, or beat_cnt reaches MAX_BURST. The beat that makes beat_cnt==MAX_BURST is the last locked beat; the next cycle is arbitrated in ARB.
  - The CPU is stalled throughout BURST.
- cpu_stall = cpu_req & !cpu_grant. A stalled CPU holds its request unchanged; the arbiter does not latch it.
- starve_cnt:
  - Cleared on any acc_gnt, or when acc_req=0.
  - Otherwise increments each cycle acc_req is denied, saturating at STARVE_LIMIT.
- Memory drive: mem_en=grant_any. mem_we, mem_addr and mem_wdata come from the winner. When idle, mem_* are 0.
- Read return:
  - rd_tag registers {CPU, ACC, NONE} for a granted read.
  - Next cycle: *_rdata=mem_rdata and *_rvalid=1 for the tagged requester, for exactly one cycle.
  - Back-to-back reads from alternating requesters each return in order, one per cycle.
- Writes produce no rvalid.
- Reset mid-burst or mid-read: state returns to ARB immediately. The pending rvalid is dropped; no data is returned after reset.

Test Plan:
- CPU load only, cpu_addr=0x100, mem returns 0xDEADBEEF → cycle N: mem_en=1, mem_we=0, cpu_stall=0; cycle N+1: cpu_rvalid=1, cpu_rdata=0xDEADBEEF, acc_rvalid=0.
- CPU and accelerator request simultaneously (acc read 0x4B000), STARVE_LIMIT=8, CPU requesting continuously → acc_gnt=0 for 8 cycles; cycle 9: acc_gnt=1, cpu_stall=1; cycle 10: CPU granted, starve_cnt=0.
- Locked accelerator burst, acc_lock=1 held for 6 writes to 0x4B000..0x4B014, MAX_BURST=4, CPU requesting → acc_gnt on 4 consecutive cycles, cpu_stall=1 throughout; CPU granted on cycle 5; the burst resumes afterwards.
- Alternating reads: CPU 0x10 then accelerator 0x20, mem data 0x11/0x22 → cpu_rvalid with 0x11, then acc_rvalid with 0x22 on consecutive cycles; never both valid.
- cpu_rd=cpu_wr=1 at 0x40 with wdata 0x55 → mem_we=1, mem_wdata=0x55, no cpu_rvalid next cycle.
- rst asserted in BURST after an accelerator read grant → acc_rvalid=0 the next cycle, acc_gnt=0, starve_cnt=0; the first post-reset CPU request is granted with no stall.
